// File: rtl/csa_accumulator_if.sv
// Operand/result handshake bundle for csa_accumulator.
//   in_valid/in_ready/in_data/in_last : operand stream into the accumulator
//   out_valid/out_ready/out_data/out_count : resolved group result
//   out_ovf : sticky overflow flag, only present when CSA_ACC_OVF_EN is defined
// master = producer/consumer side, slave = accumulator side.
interface csa_accumulator_if #(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 20,
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_data;
   logic [CNT_WIDTH-1:0] out_count;
`ifdef CSA_ACC_OVF_EN
   logic                 out_ovf;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf
   );
`else
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
`endif
endinterface

// File: rtl/csa_accumulator.sv
// Multi-operand unsigned accumulator in carry-save form.
// Operands are folded into (sum, carry) with one full-adder row per cycle, so the
// accumulate path has no carry propagation. On the last operand of a group the
// pair is resolved CHUNK bits per cycle and held on a valid/ready output.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : csa_accumulator_if.slave (operand input stream, result output,
//           operand count, optional overflow flag)
//
// Optional feature macro: CSA_ACC_OVF_EN adds the sticky exact overflow flag
// out_ovf; without it results silently wrap mod 2^ACC_WIDTH.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACC     | accepting operands, one carry-save row per transfer
// ST_RESOLVE | carry-propagate pass, one CHUNK per cycle, R cycles
// ST_HOLD    | result presented, waiting for out_ready
module csa_accumulator #(
   parameter int IN_WIDTH   = 16,
   parameter int GUARD_BITS = 4,
   parameter int CHUNK      = 8,
   parameter int CNT_WIDTH  = 8
) (
   input logic               clk,
   input logic               rst_n,
   csa_accumulator_if.slave  bus
);

   localparam int ACC_WIDTH = IN_WIDTH + GUARD_BITS;
   localparam int R         = (ACC_WIDTH + CHUNK - 1) / CHUNK;
   // Number of real bits in the top chunk; equals CHUNK when it divides evenly.
   localparam int TOP_BITS  = ACC_WIDTH - (R - 1) * CHUNK;
   localparam int K_WIDTH   = (R > 1) ? $clog2(R) : 1;
   localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(R - 1);

   typedef enum logic [1:0] {
      ST_ACC     = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic [ACC_WIDTH-1:0] carry_q, carry_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [K_WIDTH-1:0]   k_q, k_d;
   logic                 cin_q, cin_d;
   logic [ACC_WIDTH-1:0] data_q, data_d;

   logic [ACC_WIDTH-1:0] x_ext;
   logic [ACC_WIDTH-2:0] maj_lo;
   logic [CHUNK-1:0]     s_chunk;
   logic [CHUNK-1:0]     c_chunk;
   logic [CHUNK:0]       chunk_sum;
   logic                 chunk_cout;

`ifdef CSA_ACC_OVF_EN
   logic                 ovf_q, ovf_d;
   logic                 carry_msb;
`endif

   assign x_ext = ACC_WIDTH'(bus.in_data);

   // Full-adder row: only the low ACC_WIDTH-1 majority bits survive the shift;
   // the MSB majority is the carry leaving the accumulator.
   assign maj_lo = (sum_q[ACC_WIDTH-2:0] & carry_q[ACC_WIDTH-2:0])
                 | (sum_q[ACC_WIDTH-2:0] & x_ext[ACC_WIDTH-2:0])
                 | (carry_q[ACC_WIDTH-2:0] & x_ext[ACC_WIDTH-2:0]);

`ifdef CSA_ACC_OVF_EN
   assign carry_msb = (sum_q[ACC_WIDTH-1] & carry_q[ACC_WIDTH-1])
                    | (sum_q[ACC_WIDTH-1] & x_ext[ACC_WIDTH-1])
                    | (carry_q[ACC_WIDTH-1] & x_ext[ACC_WIDTH-1]);
`endif

   // Select chunk k of sum/carry; bits past ACC_WIDTH in a partial top chunk
   // read as zero, so the chunk carry lands on bit TOP_BITS of chunk_sum.
   always_comb begin
      s_chunk = '0;
      c_chunk = '0;
      for (int i = 0; i < ACC_WIDTH; i++) begin
         if ((i / CHUNK) == int'(k_q)) begin
            s_chunk[i % CHUNK] = sum_q[i];
            c_chunk[i % CHUNK] = carry_q[i];
         end
      end
      chunk_sum  = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK+1)'(cin_q);
      chunk_cout = (k_q == K_LAST) ? chunk_sum[TOP_BITS] : chunk_sum[CHUNK];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      count_d = count_q;
      k_d     = k_q;
      cin_d   = cin_q;
      data_d  = data_q;
`ifdef CSA_ACC_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_ACC: begin
            if (bus.in_valid) begin
               sum_d   = sum_q ^ carry_q ^ x_ext;
               carry_d = {maj_lo, 1'b0};
               if (count_q != '1) begin
                  count_d = count_q + CNT_WIDTH'(1);
               end
`ifdef CSA_ACC_OVF_EN
               ovf_d = ovf_q | carry_msb;
`endif
               if (bus.in_last) begin
                  state_d = ST_RESOLVE;
                  k_d     = '0;
                  cin_d   = 1'b0;
               end
            end
         end
         ST_RESOLVE: begin
            for (int i = 0; i < ACC_WIDTH; i++) begin
               if ((i / CHUNK) == int'(k_q)) begin
                  data_d[i] = chunk_sum[i % CHUNK];
               end
            end
            cin_d = chunk_cout;
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = ST_HOLD;
`ifdef CSA_ACC_OVF_EN
               ovf_d   = ovf_q | chunk_cout;
`endif
            end else begin
               k_d = k_q + K_WIDTH'(1);
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               sum_d   = '0;
               carry_d = '0;
               count_d = '0;
`ifdef CSA_ACC_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = ST_ACC;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         carry_q <= '0;
         count_q <= '0;
         k_q     <= '0;
         cin_q   <= 1'b0;
         data_q  <= '0;
`ifdef CSA_ACC_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         count_q <= count_d;
         k_q     <= k_d;
         cin_q   <= cin_d;
         data_q  <= data_d;
`ifdef CSA_ACC_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_ACC);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_data  = data_q;
   assign bus.out_count = count_q;
`ifdef CSA_ACC_OVF_EN
   assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
module tb_csa_accumulator;

   logic clk;
   logic rst_n;

   int tests_run    = 0;
   int tests_failed = 0;

   csa_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(20), .CNT_WIDTH(8)) intf ();

   csa_accumulator #(
      .IN_WIDTH(16), .GUARD_BITS(4), .CHUNK(8), .CNT_WIDTH(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (intf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] base;
      logic [15:0] step;
      int          n;
      logic [19:0] exp_data;
      logic [7:0]  exp_count;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Streams n operands back-to-back (base, base+step, ...), last one tagged,
   // then waits for out_valid and checks the resolve latency.
   task automatic send_group(input logic [15:0] base, input logic [15:0] step, input int n);
      logic [15:0] op;
      int lat;
      op = base;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("in_ready_acc", 32'(intf.in_ready), 32'd1);
         intf.in_valid = 1'b1;
         intf.in_data  = op;
         intf.in_last  = (i == n - 1);
         op = op + step;
      end
      @(negedge clk);
      intf.in_valid = 1'b0;
      intf.in_last  = 1'b0;
      lat = 0;
      while (!intf.out_valid && lat < 20) begin
         check("in_ready_busy", 32'(intf.in_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'd3);
   endtask

   task automatic check_result(input logic [19:0] d, input logic [7:0] c, input logic o);
      check("out_valid", 32'(intf.out_valid), 32'd1);
      check("out_data", 32'(intf.out_data), 32'(d));
      check("out_count", 32'(intf.out_count), 32'(c));
`ifdef CSA_ACC_OVF_EN
      check("out_ovf", 32'(intf.out_ovf), 32'(o));
`else
      if (o === 1'bx) $display("note: unknown ovf expectation");
`endif
   endtask

   task automatic handshake();
      intf.out_ready = 1'b1;
      @(negedge clk);
      intf.out_ready = 1'b0;
      check("post_hs_out_valid", 32'(intf.out_valid), 32'd0);
      check("post_hs_in_ready", 32'(intf.in_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h0000,   1, 20'h01234, 8'd1,   1'b0};
      vecs[1] = '{16'hFFFF, 16'h0000,  16, 20'hFFFF0, 8'd16,  1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000,  17, 20'h0FFEF, 8'd17,  1'b1};
      vecs[3] = '{16'h8000, 16'h0000,   4, 20'h20000, 8'd4,   1'b0};
      vecs[4] = '{16'hABCD, 16'h0000,   2, 20'h1579A, 8'd2,   1'b0};
      vecs[5] = '{16'h0001, 16'h0002,   5, 20'h00019, 8'd5,   1'b0};
      vecs[6] = '{16'h1000, 16'h1000,  15, 20'h78000, 8'd15,  1'b0};
      vecs[7] = '{16'h0001, 16'h0000, 300, 20'h0012C, 8'd255, 1'b0};
      vecs[8] = '{16'h8000, 16'h0000,  32, 20'h00000, 8'd32,  1'b1};

      rst_n          = 1'b0;
      intf.in_valid  = 1'b0;
      intf.in_data   = '0;
      intf.in_last   = 1'b0;
      intf.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_in_ready", 32'(intf.in_ready), 32'd1);
      check("rst_out_valid", 32'(intf.out_valid), 32'd0);
      check("rst_out_data", 32'(intf.out_data), 32'd0);
      check("rst_out_count", 32'(intf.out_count), 32'd0);
`ifdef CSA_ACC_OVF_EN
      check("rst_out_ovf", 32'(intf.out_ovf), 32'd0);
`endif

      for (int v = 0; v < 9; v++) begin
         send_group(vecs[v].base, vecs[v].step, vecs[v].n);
         check_result(vecs[v].exp_data, vecs[v].exp_count, vecs[v].exp_ovf);
         handshake();
      end

      // Result held under backpressure while the producer keeps pushing.
      send_group(16'hFFFF, 16'h0000, 16);
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", 32'(intf.out_valid), 32'd1);
         check("hold_out_data", 32'(intf.out_data), 32'h000FFFF0);
         check("hold_out_count", 32'(intf.out_count), 32'd16);
         check("hold_in_ready", 32'(intf.in_ready), 32'd0);
         intf.in_valid = 1'b1;
         intf.in_data  = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
         intf.in_last  = (i % 2 == 1);
         @(negedge clk);
      end
      intf.in_valid = 1'b0;
      intf.in_last  = 1'b0;
      check("hold_end_data", 32'(intf.out_data), 32'h000FFFF0);
      handshake();
      send_group(16'h0003, 16'h0000, 1);
      check_result(20'h00003, 8'd1, 1'b0);
      handshake();

      // Reset during RESOLVE abandons the group.
      @(negedge clk);
      intf.in_valid = 1'b1;
      intf.in_data  = 16'h0100;
      intf.in_last  = 1'b0;
      @(negedge clk);
      intf.in_last  = 1'b1;
      @(negedge clk);
      intf.in_valid = 1'b0;
      intf.in_last  = 1'b0;
      check("rsv_in_ready", 32'(intf.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rsv_rst_data", 32'(intf.out_data), 32'd0);
      check("rsv_rst_count", 32'(intf.out_count), 32'd0);
      check("rsv_rst_in_ready", 32'(intf.in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         check("rsv_no_valid", 32'(intf.out_valid), 32'd0);
         @(negedge clk);
      end
      send_group(16'h0005, 16'h0000, 1);
      check_result(20'h00005, 8'd1, 1'b0);
      handshake();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
